// File: rtl/pipelined_cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder: mode encodings,
// lookahead group size and the tree-depth helper.
package pipelined_cla_pkg;

    typedef enum logic [1:0] {
        MODE_ADD  = 2'b00,
        MODE_SUB  = 2'b01,
        MODE_SADD = 2'b10,
        MODE_SSUB = 2'b11
    } mode_e;

    localparam int GROUP = 4;

    // Smallest d with 4**d >= n; depth of the group lookahead tree.
    function automatic int clog4(input int n);
        int d;
        int v;
        d = 0;
        v = 1;
        for (int i = 0; i < 16; i++) begin
            if (v < n) begin
                v = v * 4;
                d = d + 1;
            end else begin
                v = v;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/cla_lookahead4.sv
// 4-bit carry-lookahead cell: internal carries plus group generate/propagate.
// Used both for bit-level groups and at every node of the group tree.
module cla_lookahead4 (
    input  logic [3:0] g_i,
    input  logic [3:0] p_i,
    input  logic       cin_i,
    output logic [3:1] c_o,
    output logic       g_o,
    output logic       p_o
);

    assign c_o[1] = g_i[0] | (p_i[0] & cin_i);
    assign c_o[2] = g_i[1] | (p_i[1] & g_i[0]) | (p_i[1] & p_i[0] & cin_i);
    assign c_o[3] = g_i[2] | (p_i[2] & g_i[1]) | (p_i[2] & p_i[1] & g_i[0])
                  | (p_i[2] & p_i[1] & p_i[0] & cin_i);
    assign g_o    = g_i[3] | (p_i[3] & g_i[2]) | (p_i[3] & p_i[2] & g_i[1])
                  | (p_i[3] & p_i[2] & p_i[1] & g_i[0]);
    assign p_o    = &p_i;

endmodule

// File: rtl/pipelined_cla_adder.sv
// Three-stage pipelined carry-lookahead adder/subtractor with optional signed
// saturation, valid/ready flow control and carry/overflow/zero flags.
module pipelined_cla_adder #(
    parameter int WIDTH  = 16,
    parameter bit SAT_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    import pipelined_cla_pkg::*;

    localparam int NG = WIDTH / GROUP;
    localparam int D  = clog4(NG);
    localparam int NL = 1 << (2 * D);

    if ((WIDTH % GROUP) != 0 || WIDTH < 4 || WIDTH > 64) begin : g_bad_width
        $error("pipelined_cla_adder: WIDTH must be a multiple of 4 in 4..64");
    end

    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic s3_valid_q, s3_valid_d;
    logic s2_ready_s, s3_ready_s;

    assign s3_ready_s = !s3_valid_q | out_ready;
    assign s2_ready_s = !s2_valid_q | s3_ready_s;
    assign in_ready   = !s1_valid_q | s2_ready_s;
    assign out_valid  = s3_valid_q;

    // Stage occupancy: a stage refills whenever its contents move on or it is empty.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        s3_valid_d = s3_valid_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
        end else begin
            s1_valid_d = s1_valid_q;
        end
        if (s2_ready_s) begin
            s2_valid_d = s1_valid_q;
        end else begin
            s2_valid_d = s2_valid_q;
        end
        if (s3_ready_s) begin
            s3_valid_d = s2_valid_q;
        end else begin
            s3_valid_d = s3_valid_q;
        end
    end

    // Stage valid bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s3_valid_q <= s3_valid_d;
        end
    end

    logic [WIDTH-1:0] bx_s;
    logic [WIDTH-1:0] s1_g_q, s1_p_q;
    logic             s1_c0_q, s1_sa_q;
    logic [1:0]       s1_mode_q;

    assign bx_s = mode[0] ? ~b : b;

    // S1: operand conditioning and per-bit generate/propagate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_g_q    <= '0;
            s1_p_q    <= '0;
            s1_c0_q   <= 1'b0;
            s1_sa_q   <= 1'b0;
            s1_mode_q <= 2'b00;
        end else if (in_valid && in_ready) begin
            s1_g_q    <= a & bx_s;
            s1_p_q    <= a ^ bx_s;
            s1_c0_q   <= mode[0] ? 1'b1 : cin;
            s1_sa_q   <= a[WIDTH-1];
            s1_mode_q <= mode;
        end
    end

    // Leaf groups, padded up to a full 4-ary tree with inert (g=0, p=0) groups.
    logic [NL-1:0] lg_s, lp_s, lc_s;

    for (genvar k = 0; k < NL; k++) begin : g_leaf
        if (k < NG) begin : g_real
            logic [3:1] unused_c_s;
            cla_lookahead4 u_cell (
                .g_i  (s1_g_q[4*k +: 4]),
                .p_i  (s1_p_q[4*k +: 4]),
                .cin_i(1'b0),
                .c_o  (unused_c_s),
                .g_o  (lg_s[k]),
                .p_o  (lp_s[k])
            );
        end else begin : g_pad
            assign lg_s[k] = 1'b0;
            assign lp_s[k] = 1'b0;
        end
    end

    // Level l combines groups of level l-1; carries flow back down to the leaves.
    for (genvar l = 1; l <= D; l++) begin : g_lvl
        localparam int N = NL >> (2 * l);
        logic [N-1:0]   g_s, p_s, c_s;
        logic [4*N-1:0] kg_s, kp_s, kc_s;

        if (l == 1) begin : g_from_leaf
            assign kg_s = lg_s;
            assign kp_s = lp_s;
        end else begin : g_from_lvl
            assign kg_s = g_lvl[l-1].g_s;
            assign kp_s = g_lvl[l-1].p_s;
        end

        if (l == D) begin : g_root
            logic unused_gp_s;
            assign c_s         = s1_c0_q;
            assign unused_gp_s = g_s[0] ^ p_s[0];
        end else begin : g_inner
            assign c_s = g_lvl[l+1].kc_s;
        end

        for (genvar j = 0; j < N; j++) begin : g_node
            cla_lookahead4 u_cell (
                .g_i  (kg_s[4*j +: 4]),
                .p_i  (kp_s[4*j +: 4]),
                .cin_i(c_s[j]),
                .c_o  (kc_s[4*j+1 +: 3]),
                .g_o  (g_s[j]),
                .p_o  (p_s[j])
            );
            assign kc_s[4*j] = c_s[j];
        end
    end

    if (D == 0) begin : g_flat
        assign lc_s = s1_c0_q;
    end else begin : g_tree
        assign lc_s = g_lvl[1].kc_s;
    end

    if (NL > NG) begin : g_pad_sink
        logic unused_lc_s;
        assign unused_lc_s = ^lc_s[NL-1:NG];
    end

    logic [WIDTH-1:0] s2_g_q, s2_p_q;
    logic [NG-1:0]    s2_gc_q;
    logic             s2_lg_q, s2_lp_q, s2_sa_q;
    logic [1:0]       s2_mode_q;

    // S2: group carry-ins from the lookahead tree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_g_q    <= '0;
            s2_p_q    <= '0;
            s2_gc_q   <= '0;
            s2_lg_q   <= 1'b0;
            s2_lp_q   <= 1'b0;
            s2_sa_q   <= 1'b0;
            s2_mode_q <= 2'b00;
        end else if (s1_valid_q && s2_ready_s) begin
            s2_g_q    <= s1_g_q;
            s2_p_q    <= s1_p_q;
            s2_gc_q   <= lc_s[NG-1:0];
            s2_lg_q   <= lg_s[NG-1];
            s2_lp_q   <= lp_s[NG-1];
            s2_sa_q   <= s1_sa_q;
            s2_mode_q <= s1_mode_q;
        end
    end

    logic [WIDTH:0] c_s;

    for (genvar k = 0; k < NG; k++) begin : g_bit
        logic unused_g_s, unused_p_s;
        cla_lookahead4 u_cell (
            .g_i  (s2_g_q[4*k +: 4]),
            .p_i  (s2_p_q[4*k +: 4]),
            .cin_i(s2_gc_q[k]),
            .c_o  (c_s[4*k+1 +: 3]),
            .g_o  (unused_g_s),
            .p_o  (unused_p_s)
        );
        assign c_s[4*k] = s2_gc_q[k];
    end
    assign c_s[WIDTH] = s2_lg_q | (s2_lp_q & s2_gc_q[NG-1]);

    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] sum_d, sum_q;
    logic             cout_d, cout_q, ovf_d, ovf_q, zero_d, zero_q, sat_s;

    // Final sum, flags and saturation clamp toward the sign of a.
    always_comb begin
        sum_d  = s2_p_q ^ c_s[WIDTH-1:0];
        cout_d = c_s[WIDTH];
        ovf_d  = c_s[WIDTH] ^ c_s[WIDTH-1];
        sat_s  = (SAT_EN == 1'b1) && s2_mode_q[1] && ovf_d;
        if (sat_s) begin
            sum_d  = s2_sa_q ? SAT_MIN : SAT_MAX;
            cout_d = 1'b0;
        end else begin
            sum_d  = sum_d;
            cout_d = cout_d;
        end
        zero_d = (sum_d == {WIDTH{1'b0}});
    end

    // S3: result registers, held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (s2_valid_q && s3_ready_s) begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench: five widths driven in lockstep, directed corner cases on
// the 16-bit instance and randomized streams scored against an arithmetic model.
module tb_pipelined_cla_adder;
    import pipelined_cla_pkg::*;

    localparam int NW = 5;
    localparam int WL [NW] = '{4, 8, 16, 32, 64};

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic [1:0]  mode;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        cin = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [63:0] a_s = 64'd0;
    logic [63:0] b_s = 64'd0;

    logic [NW-1:0] rdy_v, vld_v, co_v, ov_v, z_v;
    logic [3:0]    sum4;
    logic [7:0]    sum8;
    logic [15:0]   sum16;
    logic [31:0]   sum32;
    logic [63:0]   sum64;

    int    n_tests = 0;
    int    n_fail = 0;
    beat_t q[$];

    always #5 clk = ~clk;

    pipelined_cla_adder #(.WIDTH(4), .SAT_EN(1'b1)) u_w4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_v[0]),
        .a(a_s[3:0]), .b(b_s[3:0]), .cin(cin), .mode(mode),
        .out_valid(vld_v[0]), .out_ready(out_ready), .sum(sum4),
        .cout(co_v[0]), .ovf(ov_v[0]), .zero(z_v[0]));
    pipelined_cla_adder #(.WIDTH(8), .SAT_EN(1'b1)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_v[1]),
        .a(a_s[7:0]), .b(b_s[7:0]), .cin(cin), .mode(mode),
        .out_valid(vld_v[1]), .out_ready(out_ready), .sum(sum8),
        .cout(co_v[1]), .ovf(ov_v[1]), .zero(z_v[1]));
    pipelined_cla_adder #(.WIDTH(16), .SAT_EN(1'b1)) u_w16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_v[2]),
        .a(a_s[15:0]), .b(b_s[15:0]), .cin(cin), .mode(mode),
        .out_valid(vld_v[2]), .out_ready(out_ready), .sum(sum16),
        .cout(co_v[2]), .ovf(ov_v[2]), .zero(z_v[2]));
    pipelined_cla_adder #(.WIDTH(32), .SAT_EN(1'b1)) u_w32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_v[3]),
        .a(a_s[31:0]), .b(b_s[31:0]), .cin(cin), .mode(mode),
        .out_valid(vld_v[3]), .out_ready(out_ready), .sum(sum32),
        .cout(co_v[3]), .ovf(ov_v[3]), .zero(z_v[3]));
    pipelined_cla_adder #(.WIDTH(64), .SAT_EN(1'b1)) u_w64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_v[4]),
        .a(a_s), .b(b_s), .cin(cin), .mode(mode),
        .out_valid(vld_v[4]), .out_ready(out_ready), .sum(sum64),
        .cout(co_v[4]), .ovf(ov_v[4]), .zero(z_v[4]));

    function automatic logic [63:0] dut_sum(input int i);
        case (i)
            0:       return {60'd0, sum4};
            1:       return {56'd0, sum8};
            2:       return {48'd0, sum16};
            3:       return {32'd0, sum32};
            default: return sum64;
        endcase
    endfunction

    task automatic chk(input string tag, input int w, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s (w%0d): observed %h expected %h", tag, w, obs, exp);
        end
    endtask

    // Reference: exact signed/unsigned arithmetic on w-bit operands.
    function automatic void model(input int w, input beat_t bt, output logic [63:0] s,
                                  output logic co, output logic ov, output logic z);
        logic [65:0]        mask, ua, ub, tot_u;
        logic signed [65:0] sa, sb, tr, smax, smin;
        mask  = (66'd1 << w) - 66'd1;
        ua    = {2'b00, bt.a} & mask;
        ub    = {2'b00, bt.b} & mask;
        tot_u = bt.mode[0] ? (ua + ((~ub) & mask) + 66'd1) : (ua + ub + {65'd0, bt.cin});
        co    = tot_u[w];
        sa    = $signed(ua - (bt.a[w-1] ? (66'd1 << w) : 66'd0));
        sb    = $signed(ub - (bt.b[w-1] ? (66'd1 << w) : 66'd0));
        tr    = bt.mode[0] ? (sa - sb) : (sa + sb + $signed({65'd0, bt.cin}));
        smax  = $signed((66'd1 << (w - 1)) - 66'd1);
        smin  = $signed(66'd0 - (66'd1 << (w - 1)));
        ov    = (tr > smax) || (tr < smin);
        if (ov && bt.mode[1]) begin
            s  = ((tr > smax) ? smax[63:0] : smin[63:0]) & mask[63:0];
            co = 1'b0;
        end else begin
            s = tot_u[63:0] & mask[63:0];
        end
        z = (s == 64'd0);
    endfunction

    function automatic beat_t new_beat();
        beat_t bt;
        bt.a    = {$urandom, $urandom};
        bt.b    = {$urandom, $urandom};
        bt.cin  = 1'($urandom_range(1));
        bt.mode = 2'($urandom_range(3));
        case ($urandom_range(5))
            0:       bt.b = 64'd0 - bt.a;
            1:       bt.b = bt.a;
            default: bt.b = bt.b;
        endcase
        return bt;
    endfunction

    task automatic check_beat(input beat_t bt);
        logic [63:0] es;
        logic        eco, eov, ez;
        for (int i = 0; i < NW; i++) begin
            model(WL[i], bt, es, eco, eov, ez);
            chk("sum", WL[i], dut_sum(i), es);
            chk("cout", WL[i], {63'd0, co_v[i]}, {63'd0, eco});
            chk("ovf", WL[i], {63'd0, ov_v[i]}, {63'd0, eov});
            chk("zero", WL[i], {63'd0, z_v[i]}, {63'd0, ez});
        end
        chk("out_valid all", 0, {59'd0, vld_v}, {59'd0, 5'b11111});
    endtask

    // Cycle-by-cycle streaming with a scoreboard; rnd selects random handshakes.
    task automatic stream(input int nbeats, input bit rnd);
        int          sent = 0;
        int          cyc = 0;
        int          budget = nbeats * 8 + 50;
        logic        held_v = 1'b0;
        logic [63:0] held_s = 64'd0;
        beat_t       cur;
        cur = new_beat();
        while ((sent < nbeats || q.size() > 0) && cyc < budget) begin
            @(negedge clk);
            if (held_v) begin
                chk("stall sum stable", 16, dut_sum(2), held_s);
                chk("stall valid held", 16, {63'd0, vld_v[2]}, 64'd1);
            end
            in_valid  = (sent < nbeats) && (rnd ? ($urandom_range(3) != 0) : 1'b1);
            out_ready = rnd ? 1'($urandom_range(1)) : ((cyc % 3) == 0);
            a_s  = cur.a;
            b_s  = cur.b;
            cin  = cur.cin;
            mode = cur.mode;
            #1;
            chk("in_ready", 0, {59'd0, rdy_v},
                (q.size() == 3 && !out_ready) ? 64'd0 : {59'd0, 5'b11111});
            if (q.size() == 0) begin
                chk("idle out_valid", 0, {59'd0, vld_v}, 64'd0);
            end
            if (vld_v[2] && out_ready && q.size() > 0) begin
                check_beat(q.pop_front());
            end
            if (in_valid && rdy_v[2]) begin
                q.push_back(cur);
                sent++;
                cur = new_beat();
            end
            held_v = vld_v[2] && !out_ready;
            held_s = dut_sum(2);
            cyc++;
        end
        chk("stream drained", 0, 64'(q.size() + nbeats - sent), 64'd0);
        q.delete();
        in_valid = 1'b0;
    endtask

    task automatic directed(input string tag, input logic [15:0] da, input logic [15:0] db,
                            input logic dcin, input logic [1:0] dm, input logic [15:0] es,
                            input logic eco, input logic eov, input logic ez);
        int lat;
        @(negedge clk);
        a_s       = {48'd0, da};
        b_s       = {48'd0, db};
        cin       = dcin;
        mode      = dm;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("accept ready", 16, {63'd0, rdy_v[2]}, 64'd1);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!vld_v[2] && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, 16, 64'(lat), 64'd3);
        chk({tag, " sum"}, 16, dut_sum(2), {48'd0, es});
        chk({tag, " cout"}, 16, {63'd0, co_v[2]}, {63'd0, eco});
        chk({tag, " ovf"}, 16, {63'd0, ov_v[2]}, {63'd0, eov});
        chk({tag, " zero"}, 16, {63'd0, z_v[2]}, {63'd0, ez});
        @(posedge clk);
    endtask

    initial begin
        logic stale;

        // Reset state.
        #12;
        chk("reset out_valid", 0, {59'd0, vld_v}, 64'd0);
        chk("reset sum", 16, dut_sum(2), 64'd0);
        chk("reset flags", 0, {49'd0, co_v, ov_v, z_v}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("in_ready after reset", 0, {59'd0, rdy_v}, {59'd0, 5'b11111});

        // Directed corner cases on the 16-bit instance.
        directed("add carry", 16'h00FF, 16'h0001, 1'b0, MODE_ADD, 16'h0100, 1'b0, 1'b0, 1'b0);
        directed("add wrap", 16'hFFFF, 16'h0001, 1'b0, MODE_ADD, 16'h0000, 1'b1, 1'b0, 1'b1);
        directed("sub neg", 16'h0005, 16'h0007, 1'b0, MODE_SUB, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        directed("sadd pos", 16'h7FFF, 16'h0001, 1'b0, MODE_SADD, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        directed("ssub neg", 16'h8000, 16'h0001, 1'b0, MODE_SSUB, 16'h8000, 1'b0, 1'b1, 1'b0);
        directed("add ovf", 16'h7FFF, 16'h0001, 1'b0, MODE_ADD, 16'h8000, 1'b0, 1'b1, 1'b0);
        directed("sub cin", 16'h0003, 16'h0003, 1'b1, MODE_SUB, 16'h0000, 1'b1, 1'b0, 1'b1);
        directed("add cin", 16'h0001, 16'h0001, 1'b1, MODE_ADD, 16'h0003, 1'b0, 1'b0, 1'b0);
        directed("ssub pos", 16'h7FFF, 16'hFFFF, 1'b0, MODE_SSUB, 16'h7FFF, 1'b0, 1'b1, 1'b0);

        // Back-to-back beats with out_ready 1,0,0,...
        stream(10, 1'b0);

        // Reset with three beats in flight.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a_s       = {$urandom, $urandom};
            b_s       = {$urandom, $urandom};
            in_valid  = 1'b1;
            out_ready = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("full stalled in_ready", 0, {59'd0, rdy_v}, 64'd0);
        chk("full out_valid", 0, {59'd0, vld_v}, {59'd0, 5'b11111});
        rst_n = 1'b0;
        #1;
        chk("async reset out_valid", 0, {59'd0, vld_v}, 64'd0);
        chk("async reset sum", 64, dut_sum(4), 64'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        stale     = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            stale = stale | (|vld_v);
        end
        chk("no stale result", 0, {63'd0, stale}, 64'd0);

        // Long randomized run across all widths.
        stream(10000, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
